// File: rtl/interrupt_controller.sv
// Single-level interrupt sequencer: masks requests with mie, issues a one-cycle trap
// for the lowest-index pending line, holds it in service until mret, then acknowledges it.
module interrupt_controller #(
  parameter int IRQ_NUM = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IRQ_NUM-1:0] irq_req_i,
  input  logic [31:0]        mie_i,
  input  logic               exception_i,
  input  logic               stall_i,
  input  logic               mret_i,
  output logic               irq_o,
  output logic [31:0]        irq_cause_o,
  output logic [IRQ_NUM-1:0] irq_ret_o,
  output logic               busy_o,
  output logic               dbg_state_o
);

  localparam int IDX_W = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, win;
  logic [IRQ_NUM-1:0] pending, ack_mask_q;
  logic               unused_mie;

  // The line acknowledged last cycle is still held by its peripheral, so hide it for one cycle.
  assign pending     = irq_req_i & mie_i[16 +: IRQ_NUM] & ~ack_mask_q;
  assign unused_mie  = ^mie_i;
  assign dbg_state_o = (state_q == SERVICE);

  always_comb begin
    win = '0;
    for (int k = IRQ_NUM - 1; k >= 0; k--) begin
      if (pending[k]) win = IDX_W'(k);
    end
  end

  always_comb begin
    state_d     = state_q;
    irq_o       = 1'b0;
    irq_cause_o = 32'h0;
    irq_ret_o   = '0;
    busy_o      = 1'b0;
    case (state_q)
      IDLE: begin
        if ((|pending) && rst_i) begin
          irq_cause_o = 32'h8000_0010 + 32'(win);
          if (!exception_i && !stall_i) begin
            irq_o   = 1'b1;
            state_d = SERVICE;
          end
        end
      end
      SERVICE: begin
        busy_o      = 1'b1;
        irq_cause_o = 32'h8000_0010 + 32'(idx_q);
        if (mret_i) begin
          irq_ret_o = IRQ_NUM'(1) << idx_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      ack_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      ack_mask_q <= irq_ret_o;
      if (state_q == IDLE && state_d == SERVICE) idx_q <= win;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios then random traffic, all checked
// against a cycle-level behavioural model of the sequencer.
module tb_interrupt_controller;
  localparam int N = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [N-1:0]  irq_req_i;
  logic [31:0]   mie_i;
  logic          exception_i, stall_i, mret_i;
  logic          irq_o;
  logic [31:0]   irq_cause_o;
  logic [N-1:0]  irq_ret_o;
  logic          busy_o;
  logic          dbg_state_o;

  int checks = 0;
  int errors = 0;

  // Model state: whether a line is in service, which one, and the line hidden this cycle.
  bit            m_busy;
  int            m_idx;
  int            m_mask;
  logic [N-1:0]  exp_q[$];

  logic          o_irq, o_busy;
  logic [31:0]   o_cause;
  logic [N-1:0]  o_ret;

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  interrupt_controller #(.IRQ_NUM(N)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .irq_req_i   (irq_req_i),
    .mie_i       (mie_i),
    .exception_i (exception_i),
    .stall_i     (stall_i),
    .mret_i      (mret_i),
    .irq_o       (irq_o),
    .irq_cause_o (irq_cause_o),
    .irq_ret_o   (irq_ret_o),
    .busy_o      (busy_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_idx  = 0;
    m_mask = -1;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [N-1:0] req, input logic [31:0] mie,
                       input logic exc, input logic stall, input logic mret);
    irq_req_i   = req;
    mie_i       = mie;
    exception_i = exc;
    stall_i     = stall;
    mret_i      = mret;
  endtask

  // One clock: check outputs mid-cycle against the model, advance the model, cross the edge.
  task automatic cycle(input string tag);
    logic [N-1:0] pend;
    int           w;
    logic         e_irq;
    logic [31:0]  e_cause;
    logic [N-1:0] e_ret;
    @(negedge clk_i);
    pend = irq_req_i & mie_i[16 +: N];
    if (m_mask >= 0) pend[m_mask] = 1'b0;
    w = lowest(pend);
    e_ret = '0;
    if (!m_busy) begin
      e_irq   = (w >= 0) && !exception_i && !stall_i;
      e_cause = (w >= 0) ? 32'h8000_0010 + 32'(w) : 32'h0;
    end else begin
      e_irq   = 1'b0;
      e_cause = 32'h8000_0010 + 32'(m_idx);
      if (mret_i && exp_q.size() > 0) e_ret = exp_q[0];
    end
    o_irq = irq_o; o_cause = irq_cause_o; o_ret = irq_ret_o; o_busy = busy_o;
    chk({tag, "_irq"},   32'(irq_o),       32'(e_irq));
    chk({tag, "_cause"}, irq_cause_o,      e_cause);
    chk({tag, "_ret"},   32'(irq_ret_o),   32'(e_ret));
    chk({tag, "_busy"},  32'(busy_o),      32'(m_busy));
    chk({tag, "_state"}, 32'(dbg_state_o), 32'(m_busy));
    if (!m_busy) begin
      m_mask = -1;
      if (e_irq) begin
        m_busy = 1'b1;
        m_idx  = w;
        exp_q.push_back(N'(1) << w);
      end
    end else if (mret_i) begin
      m_busy = 1'b0;
      m_mask = m_idx;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      m_mask = -1;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1'b0;
    drive(16'h0001, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    model_reset();
    #2;
    chk("rst_irq",   32'(irq_o),     32'h0);
    chk("rst_cause", irq_cause_o,    32'h0);
    chk("rst_busy",  32'(busy_o),    32'h0);
    chk("rst_ret",   32'(irq_ret_o), 32'h0);
    drive(16'h0000, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // single line from reset
    cycles("t1_idle", 4);
    drive(16'h0001, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    cycle("t1_take");
    chk("t1_irq_hi", 32'(o_irq), 32'h1);
    chk("t1_cause",  o_cause,    32'h8000_0010);
    cycles("t1_svc", 6);
    chk("t1_busy", 32'(o_busy), 32'h1);
    chk("t1_once", 32'(o_irq),  32'h0);
    drive(16'h0001, 32'h0001_0000, 1'b0, 1'b0, 1'b1);
    cycle("t1_mret");
    chk("t1_ret", 32'(o_ret), 32'h0001);
    drive(16'h0001, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    cycle("t1_after");
    chk("t1_no_retake", 32'(o_irq),  32'h0);
    chk("t1_idle_busy", 32'(o_busy), 32'h0);
    drive(16'h0000, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    cycle("t1_drop");

    // priority and mask
    drive(16'h0012, 32'h0010_0000, 1'b0, 1'b0, 1'b0);
    cycle("t2_take");
    chk("t2_cause", o_cause, 32'h8000_0014);
    cycles("t2_svc", 3);
    drive(16'h0012, 32'h0010_0000, 1'b0, 1'b0, 1'b1);
    cycle("t2_mret");
    chk("t2_ret", 32'(o_ret), 32'h0010);
    drive(16'h0002, 32'h0010_0000, 1'b0, 1'b0, 1'b0);
    cycles("t2_masked", 3);
    chk("t2_masked_irq", 32'(o_irq), 32'h0);

    // blocking by stall, then exception
    drive(16'h0001, 32'h0001_0000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle("t3_stall");
      chk("t3_stall_irq", 32'(o_irq), 32'h0);
    end
    drive(16'h0001, 32'h0001_0000, 1'b1, 1'b0, 1'b0);
    cycle("t3_exc");
    chk("t3_exc_irq", 32'(o_irq), 32'h0);
    drive(16'h0001, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    cycle("t3_take");
    chk("t3_irq", 32'(o_irq), 32'h1);

    // events ignored in service, then back-to-back
    drive(16'h0005, 32'hFFFF_0000, 1'b1, 1'b0, 1'b0);
    cycle("t4_ign");
    chk("t4_ign_irq",   32'(o_irq), 32'h0);
    chk("t4_ign_cause", o_cause,    32'h8000_0010);
    drive(16'h0005, 32'hFFFF_0000, 1'b0, 1'b0, 1'b1);
    cycle("t4_mret0");
    chk("t4_ret0", 32'(o_ret), 32'h0001);
    drive(16'h0005, 32'hFFFF_0000, 1'b0, 1'b0, 1'b0);
    cycle("t4_b2b");
    chk("t4_b2b_irq",   32'(o_irq), 32'h1);
    chk("t4_b2b_cause", o_cause,    32'h8000_0012);
    drive(16'h0005, 32'hFFFF_0000, 1'b0, 1'b0, 1'b1);
    cycle("t4_mret2");
    chk("t4_ret2", 32'(o_ret), 32'h0004);
    drive(16'h0000, 32'hFFFF_0000, 1'b0, 1'b0, 1'b1);
    cycles("t4_idle_mret", 2);
    chk("t4_idle_ret", 32'(o_ret), 32'h0);

    // reset mid-service
    drive(16'h0008, 32'hFFFF_0000, 1'b0, 1'b0, 1'b0);
    cycle("t5_take");
    chk("t5_cause", o_cause, 32'h8000_0013);
    mret_i = 1'b1;
    #2;
    rst_i = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy_o),    32'h0);
    chk("t5_rst_ret",  32'(irq_ret_o), 32'h0);
    chk("t5_rst_irq",  32'(irq_o),     32'h0);
    model_reset();
    mret_i = 1'b0;
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    cycle("t5_retake");
    chk("t5_retake_irq", 32'(o_irq), 32'h1);
    drive(16'h0000, 32'hFFFF_0000, 1'b0, 1'b0, 1'b1);
    cycle("t5_mret");

    // random traffic
    for (int i = 0; i < 500; i++) begin
      drive(N'($urandom_range(0, 65535)),
            {16'($urandom_range(0, 65535)), 16'h0000},
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0));
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Interrupt sequencer sitting between the peripheral interrupt lines, the core's control unit and the CSR controller. It masks pending requests with the `mie` value from the CSR controller and picks the highest-priority one. It then raises a single-cycle trap request together with an `mcause` code, which drive the CSR controller's trap and cause inputs. It holds the service state until the handler executes `mret`, then acknowledges the serviced source. It supports one interrupt in service at a time, with no nesting.

## Interface
Parameters:
- `IRQ_NUM`, default 16: number of interrupt lines, legal range 1..16.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `irq_req_i`  in  IRQ_NUM  level-sensitive requests. Each peripheral holds its line until it sees its `irq_ret_o` bit.
- `mie_i`  in  32  `mie` CSR value. Line k is enabled by bit `mie_i[16+k]`.
- `exception_i`  in  1  the core is taking a synchronous exception this cycle.
- `stall_i`  in  1  the core is stalled; a trap must not be issued.
- `mret_i`  in  1  an `mret` is retiring this cycle.
- `irq_o`  out  1  trap request to the core and to the CSR controller's `trap_i`.
- `irq_cause_o`  out  32  cause code to the CSR controller's `mcause_i`.
- `irq_ret_o`  out  IRQ_NUM  one-hot acknowledge to the peripherals.
- `busy_o`  out  1  an interrupt is in service.

## Operation
- Masking:
  - `pending = irq_req_i & mie_i[16+IRQ_NUM-1:16]`.
  - `win` is the lowest index set in `pending`; index 0 has the highest priority.
- FSM with two states, IDLE and SERVICE, plus a registered index `idx_q` of width clog2(IRQ_NUM), minimum 1 bit.
- IDLE:
  - `irq_o = |pending & ~exception_i & ~stall_i`, combinational.
  - `irq_cause_o = 32'h8000_0010 + win` when `|pending`, else 0.
  - When `irq_o` is 1, at the edge: `idx_q <= win` and state goes to SERVICE.
  - When `exception_i` or `stall_i` is high, the request is deferred and the FSM stays in IDLE. The synchronous exception always wins.
- SERVICE:
  - `irq_o = 0`.
  - `irq_cause_o = 32'h8000_0010 + idx_q`, held constant.
  - `busy_o = 1`.
  - New requests and `mie_i` changes are ignored; they stay pending.
  - `exception_i` during SERVICE has no effect on the FSM.
  - On `mret_i`: `irq_ret_o = 1 << idx_q` in the same cycle (combinational), and the state goes to IDLE at that edge.
- `mret_i` in IDLE is ignored, and `irq_ret_o` stays 0.
- `irq_ret_o` is zero in every cycle except the SERVICE cycle where `mret_i` is high.
- `idx_q` is written only on the IDLE→SERVICE transition.

## Timing
- Reset (`rst_i` = 0, asynchronous):
  - Immediately: state = IDLE, `idx_q = 0`, `busy_o = 0`, `irq_ret_o = 0`.
  - `irq_o` and `irq_cause_o` then follow the IDLE equations. They are forced to 0 while `rst_i` is low.
  - Reset during SERVICE abandons the interrupt without an acknowledge.
- Latency:
  - A request that is pending, enabled and unblocked in cycle N gives `irq_o` = 1 in cycle N.
  - `busy_o` = 1 from cycle N+1.
  - `irq_o` is high for exactly one cycle per taken interrupt.
- Return:
  - `mret_i` in cycle M gives `irq_ret_o` in cycle M.
  - State is IDLE in M+1.
  - In M+1 the peripheral has not yet seen its acknowledge edge. The acknowledged index is therefore masked from `pending` for one cycle, cycle M+1 only, so the same request is not re-taken.
- Back-to-back: another enabled pending line is taken in M+1 at the earliest.
- Simultaneous events:
  - A new request arriving on the `mret_i` cycle is taken no earlier than M+1.
  - If `exception_i` and a pending request occur in the same IDLE cycle, `irq_o` = 0 and the interrupt is taken on the first later cycle with `exception_i` = 0 and `stall_i` = 0.

## Test plan
- Single line, from reset:
  - Stimulus: `mie_i = 32'h0001_0000`, `irq_req_i[0]` raised at cycle 5.
  - Required: `irq_o` = 1 at cycle 5 only, `irq_cause_o` = 32'h8000_0010.
  - Then `busy_o` = 1; `mret_i` at cycle 12 gives `irq_ret_o` = 16'h0001 at cycle 12 and `busy_o` = 0 at cycle 13.
- Priority and mask:
  - Stimulus: `irq_req_i = 16'h0012`, `mie_i = 32'h0010_0000`.
  - Required: line 4 is taken, `irq_cause_o` = 32'h8000_0014; line 1 is never taken while masked.
- Blocking:
  - Stimulus: request held with `stall_i` = 1 for 3 cycles, then `exception_i` = 1 for 1 cycle.
  - Required: `irq_o` = 0 throughout; `irq_o` = 1 on the first cycle where both are 0.
- Back-to-back:
  - Stimulus: lines 0 and 2 both pending.
  - Required: `mret_i` for line 0 gives `irq_ret_o` = 16'h0001.
  - If line 0 is still held in the next cycle: no re-trap; line 2 is taken with `irq_cause_o` = 32'h8000_0012.
- Ignored events:
  - Stimulus: `mret_i` in IDLE.
  - Required: `irq_ret_o` = 0 and the FSM does not move.
  - Stimulus: new request and `exception_i` during SERVICE.
  - Required: `irq_o` = 0 and `irq_cause_o` unchanged.
- Reset mid-service:
  - Stimulus: deassert `rst_i` asynchronously in SERVICE.
  - Required: `busy_o`, `irq_ret_o` and `irq_o` go to 0 at once.
  - After release, the still-pending request is re-taken.
